// File: rtl/wb_arbiter_if.sv
// Register-file write-port bus between the writeback stage, the multi-cycle
// unit and the arbiter that owns the single register-file write port.
interface wb_arbiter_if;
  logic        pipe_write_n;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        pipe_stall;
  logic        rf_write_n;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;

  // Requesters (writeback stage + multi-cycle unit) side
  modport master (
    output pipe_write_n, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
    input  mc_ready, pipe_stall, rf_write_n, rf_rd, rf_data
  );

  // Arbiter side
  modport slave (
    input  pipe_write_n, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
    output mc_ready, pipe_stall, rf_write_n, rf_rd, rf_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter. Writeback-stage writes go straight
// through; multi-cycle results are queued in a small FIFO and drain when the
// pipeline leaves the port idle. A head-age counter forces a pipeline stall
// so a buffered result can never starve.
module wb_arbiter #(
  parameter int DEPTH   = 2,
  parameter int AGE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW = $clog2(AGE_MAX + 1);
  localparam logic [PW:0]   DEPTH_C = DEPTH[PW:0];
  localparam logic [AW-1:0] AGE_LIM = AGE_MAX[AW-1:0];

  typedef struct packed {
    logic        vld;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t          buf_q [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   count;
  logic [AW-1:0] age;

  logic        rf_write_n_q;
  logic [4:0]  rf_rd_q;
  logic [31:0] rf_data_q;

  logic empty, stall, pipe_grant, push, pop;
  ent_t head;

  // Grant decision: pipeline first unless the head has aged out
  always_comb begin
    empty      = (count == '0);
    stall      = (age == AGE_LIM);
    head       = buf_q[rptr];
    pipe_grant = !bus.pipe_write_n && (bus.pipe_rd != 5'd0) && !stall;
    // A head that is a bubble (invalidated) still pops, just without a write
    pop        = !empty && (stall || !pipe_grant);
    // Results for x0 are accepted but dropped
    push       = bus.mc_valid && (count < DEPTH_C) && (bus.mc_rd != 5'd0);
  end

  assign bus.mc_ready   = (count < DEPTH_C);
  assign bus.pipe_stall = stall;
  assign bus.rf_write_n = rf_write_n_q;
  assign bus.rf_rd      = rf_rd_q;
  assign bus.rf_data    = rf_data_q;

  // FIFO storage, invalidation by younger pipeline writes, pointers, count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (pipe_grant) begin
        for (int i = 0; i < DEPTH; i++)
          if (buf_q[i].rd == bus.pipe_rd) buf_q[i].vld <= 1'b0;
      end
      // Pushed after the invalidate so a same-cycle mc result stays valid
      if (push) begin
        buf_q[wptr] <= '{vld: 1'b1, rd: bus.mc_rd, data: bus.mc_data};
        wptr        <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head age: counts cycles the head is passed over, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 age <= '0;
    else if (empty || pop)   age <= '0;
    else if (age != AGE_LIM) age <= age + 1'b1;
  end

  // Registered register-file write port; address/data hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_write_n_q <= 1'b1;
      rf_rd_q      <= '0;
      rf_data_q    <= '0;
    end else begin
      rf_write_n_q <= 1'b1;
      if (pipe_grant) begin
        rf_write_n_q <= 1'b0;
        rf_rd_q      <= bus.pipe_rd;
        rf_data_q    <= bus.pipe_data;
      end else if (pop && head.vld) begin
        rf_write_n_q <= 1'b0;
        rf_rd_q      <= head.rd;
        rf_data_q    <= head.data;
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a queue-based model.
module tb_wb_arbiter;
  localparam int DEPTH   = 2;
  localparam int AGE_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  wb_arbiter_if bus ();

  wb_arbiter #(.DEPTH(DEPTH), .AGE_MAX(AGE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          v;
  } ent_t;

  ent_t        q[$];
  int          age;
  logic        exp_wn;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic pwn, input logic [4:0] prd, input logic [31:0] pd,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    bus.pipe_write_n = pwn;
    bus.pipe_rd      = prd;
    bus.pipe_data    = pd;
    bus.mc_valid     = mv;
    bus.mc_rd        = mrd;
    bus.mc_data      = md;
  endtask

  task automatic idle();
    set_in(1'b1, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic model_clear();
    q.delete();
    age      = 0;
    exp_wn   = 1'b1;
    exp_rd   = 5'd0;
    exp_data = 32'd0;
  endtask

  // One clock: check state-derived outputs, advance the model, check rf port
  task automatic cycle();
    bit   stall, preq, push, pop, had;
    ent_t e;
    chk("mc_ready", bus.mc_ready, q.size() < DEPTH);
    stall = (age == AGE_MAX);
    chk("pipe_stall", bus.pipe_stall, stall);
    preq = !bus.pipe_write_n && bus.pipe_rd != 0 && !stall;
    push = bus.mc_valid && q.size() < DEPTH && bus.mc_rd != 0;
    had  = q.size() > 0;
    exp_wn = 1'b1;
    if (preq) begin
      exp_wn   = 1'b0;
      exp_rd   = bus.pipe_rd;
      exp_data = bus.pipe_data;
      foreach (q[i]) if (q[i].rd == bus.pipe_rd) q[i].v = 0;
    end
    pop = had && !preq;
    if (pop) begin
      e = q.pop_front();
      if (e.v) begin
        exp_wn   = 1'b0;
        exp_rd   = e.rd;
        exp_data = e.data;
      end
    end
    if (pop || !had) age = 0;
    else if (age < AGE_MAX) age++;
    if (push) q.push_back('{rd: bus.mc_rd, data: bus.mc_data, v: 1'b1});
    @(posedge clk);
    #1;
    chk("rf_write_n", bus.rf_write_n, exp_wn);
    chk("rf_rd", bus.rf_rd, exp_rd);
    chk("rf_data", bus.rf_data, exp_data);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rf_write_n", bus.rf_write_n, 1'b1);
    chk("rst_mc_ready", bus.mc_ready, 1'b1);
    chk("rst_pipe_stall", bus.pipe_stall, 1'b0);
    chk("rst_rf_rd", bus.rf_rd, 5'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    idle();
    model_clear();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("init_rf_write_n", bus.rf_write_n, 1'b1);
    chk("init_rf_data", bus.rf_data, 32'd0);
    chk("init_mc_ready", bus.mc_ready, 1'b1);
    rst = 1'b0;

    // Pipeline-only write, first edge after reset release
    set_in(1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    cycle();
    chk("p_only_wn", bus.rf_write_n, 1'b0);
    chk("p_only_rd", bus.rf_rd, 5'd5);
    chk("p_only_data", bus.rf_data, 32'hDEADBEEF);
    chk("p_only_ready", bus.mc_ready, 1'b1);

    // Collision: pipeline first, buffered result next idle cycle
    set_in(1'b0, 5'd3, 32'h33, 1'b1, 5'd7, 32'h11);
    cycle();
    chk("coll_rd0", bus.rf_rd, 5'd3);
    idle();
    cycle();
    chk("coll_wn1", bus.rf_write_n, 1'b0);
    chk("coll_rd1", bus.rf_rd, 5'd7);
    chk("coll_data1", bus.rf_data, 32'h11);
    cycle();
    chk("coll_idle", bus.rf_write_n, 1'b1);

    // Starvation: head rd=9 passed over four times, then forced through
    set_in(1'b1, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    cycle();
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b0, i[4:0], 32'h100 + i, 1'b0, 5'd0, 32'd0);
      cycle();
      chk("starve_pipe_rd", bus.rf_rd, i);
    end
    set_in(1'b0, 5'd5, 32'h105, 1'b0, 5'd0, 32'd0);
    chk("starve_stall", bus.pipe_stall, 1'b1);
    cycle();
    chk("starve_head_rd", bus.rf_rd, 5'd9);
    chk("starve_head_data", bus.rf_data, 32'h99);
    chk("starve_unstall", bus.pipe_stall, 1'b0);
    cycle();
    chk("starve_resume", bus.rf_rd, 5'd5);

    // Full: two buffered while pipeline busy, third held until a pop
    set_in(1'b0, 5'd1, 32'h1, 1'b1, 5'd10, 32'hA0);
    cycle();
    set_in(1'b0, 5'd2, 32'h2, 1'b1, 5'd11, 32'hB0);
    cycle();
    chk("full_ready0", bus.mc_ready, 1'b0);
    set_in(1'b0, 5'd1, 32'h3, 1'b1, 5'd12, 32'hC0);
    cycle();
    set_in(1'b1, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC0);
    chk("full_ready_held", bus.mc_ready, 1'b0);
    cycle();
    chk("full_pop_rd", bus.rf_rd, 5'd10);
    chk("full_ready1", bus.mc_ready, 1'b1);
    cycle();
    chk("full_pop2_rd", bus.rf_rd, 5'd11);
    idle();
    cycle();
    chk("full_third_rd", bus.rf_rd, 5'd12);
    chk("full_third_data", bus.rf_data, 32'hC0);

    // Invalidate: buffered rd=6 superseded by a pipeline write to rd=6
    set_in(1'b0, 5'd1, 32'h1, 1'b1, 5'd6, 32'h66);
    cycle();
    set_in(1'b0, 5'd6, 32'hA, 1'b0, 5'd0, 32'd0);
    cycle();
    chk("inv_data", bus.rf_data, 32'hA);
    idle();
    cycle();
    chk("inv_bubble_wn", bus.rf_write_n, 1'b1);
    cycle();
    chk("inv_empty_wn", bus.rf_write_n, 1'b1);
    chk("inv_rd_hold", bus.rf_rd, 5'd6);

    // Reset with two entries buffered
    set_in(1'b0, 5'd1, 32'h1, 1'b1, 5'd20, 32'h20);
    cycle();
    set_in(1'b0, 5'd2, 32'h2, 1'b1, 5'd21, 32'h21);
    cycle();
    idle();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("post_rst_no_write", bus.rf_write_n, 1'b1);
    end

    // Randomized traffic with one reset in the middle
    for (int n = 0; n < 2000; n++) begin
      set_in(($urandom_range(0, 4) == 0), 5'($urandom_range(0, 7)), $urandom,
             ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
      if (n == 1000) begin
        idle();
        do_reset();
      end else begin
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
